cdb_broadcaster: RTL and testbench

Transmit side of the common data bus (CDB). Collects completed results from N_FU functional units, buffers them in small per-FU FIFOs and drives up to 4 results per cycle onto the 4-lane CDB. Every reservation station and the ROB consume this bus. Round-robin arbitration across FUs, with backpressure to the FUs through per-FU ready signals.

---
 rtl/cdb_pkg.sv | 50 +++++
 rtl/cdb_broadcaster_if.sv | 29 ++
 rtl/cdb_result_fifo.sv | 73 +++++++
 rtl/cdb_broadcaster.sv | 115 +++++++++++
 tb/tb_cdb_broadcaster.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cdb_pkg.sv
// Common data bus shared definitions.
// Used by the CDB broadcaster, reservation stations and the ROB so that all
// agree on entry layout and on lane packing (lane 0 = MSB slice of a flat bus).
package cdb_pkg;

    localparam int ROB_W     = 4;
    localparam int DATA_W    = 16;
    localparam int CDB_LANES = 4;

    typedef struct packed {
        logic [ROB_W-1:0]  rob_index;
        logic [DATA_W-1:0] result;
    } cdb_entry_t;

    // Index k = lane k.
    typedef cdb_entry_t [CDB_LANES-1:0] cdb_lanes_t;

    function automatic logic [CDB_LANES-1:0] cdb_pack_valid(input logic [CDB_LANES-1:0] vld);
        logic [CDB_LANES-1:0] f;
        f = '0;
        for (int k = 0; k < CDB_LANES; k++) f[CDB_LANES-1-k] = vld[k];
        return f;
    endfunction

    function automatic logic [CDB_LANES*ROB_W-1:0] cdb_pack_rob(input cdb_lanes_t l);
        logic [CDB_LANES*ROB_W-1:0] f;
        f = '0;
        for (int k = 0; k < CDB_LANES; k++) f[ROB_W*(CDB_LANES-1-k) +: ROB_W] = l[k].rob_index;
        return f;
    endfunction

    function automatic logic [CDB_LANES*DATA_W-1:0] cdb_pack_result(input cdb_lanes_t l);
        logic [CDB_LANES*DATA_W-1:0] f;
        f = '0;
        for (int k = 0; k < CDB_LANES; k++) f[DATA_W*(CDB_LANES-1-k) +: DATA_W] = l[k].result;
        return f;
    endfunction

    function automatic cdb_lanes_t cdb_unpack(input logic [CDB_LANES*ROB_W-1:0]  rob_flat,
                                              input logic [CDB_LANES*DATA_W-1:0] res_flat);
        cdb_lanes_t l;
        l = '0;
        for (int k = 0; k < CDB_LANES; k++) begin
            l[k].rob_index = rob_flat[ROB_W*(CDB_LANES-1-k) +: ROB_W];
            l[k].result    = res_flat[DATA_W*(CDB_LANES-1-k) +: DATA_W];
        end
        return l;
    endfunction

endpackage

// File: rtl/cdb_broadcaster_if.sv
// FU-result / CDB bundle for the broadcaster.
//   fu_valid_flat / fu_rob_index_flat / fu_result_flat : FU results, FU i at slice i
//   fu_ready_flat                                       : per-FU accept
//   cdb_valid_flat / cdb_rob_index_flat / cdb_result_flat : 4-lane CDB, lane 0 at MSB slice
// master = FU / consumer side, slave = broadcaster.
interface cdb_broadcaster_if #(
    parameter int N_FU   = 6,
    parameter int ROB_W  = 4,
    parameter int DATA_W = 16,
    parameter int LANES  = 4
);
    logic [N_FU-1:0]         fu_valid_flat;
    logic [ROB_W*N_FU-1:0]   fu_rob_index_flat;
    logic [DATA_W*N_FU-1:0]  fu_result_flat;
    logic [N_FU-1:0]         fu_ready_flat;
    logic [LANES-1:0]        cdb_valid_flat;
    logic [LANES*ROB_W-1:0]  cdb_rob_index_flat;
    logic [LANES*DATA_W-1:0] cdb_result_flat;

    modport master (
        output fu_valid_flat, fu_rob_index_flat, fu_result_flat,
        input  fu_ready_flat, cdb_valid_flat, cdb_rob_index_flat, cdb_result_flat
    );

    modport slave (
        input  fu_valid_flat, fu_rob_index_flat, fu_result_flat,
        output fu_ready_flat, cdb_valid_flat, cdb_rob_index_flat, cdb_result_flat
    );
endinterface

// File: rtl/cdb_result_fifo.sv
// Per-FU result FIFO (DEPTH entries, DEPTH a power of two).
//   clk, rst   : clock, synchronous active-high reset
//   flush      : clears all entries; a same-cycle push is discarded
//   push, din  : write an entry (ignored when full)
//   pop        : retire the head (ignored when empty)
//   head       : oldest entry, valid when count != 0
//   count      : occupancy
//   not_full   : count < DEPTH; independent of a same-cycle pop
module cdb_result_fifo
    import cdb_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  cdb_entry_t       din,
    output cdb_entry_t       head,
    output logic [CNT_W-1:0] count,
    output logic             not_full
);

    cdb_entry_t       mem_q [DEPTH];
    cdb_entry_t       mem_d [DEPTH];
    logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok, pop_ok;

    always_comb begin
        push_ok = push & (count_q < CNT_W'(DEPTH));
        pop_ok  = pop & (count_q != '0);
        mem_d   = mem_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        if (flush) begin
            wr_d    = '0;
            rd_d    = '0;
            count_d = '0;
        end else begin
            if (push_ok) begin
                mem_d[wr_q] = din;
                wr_d        = wr_q + PTR_W'(1);
            end
            if (pop_ok) rd_d = rd_q + PTR_W'(1);
            count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: occupancy alone decides what is visible.
    always_ff @(posedge clk) mem_q <= mem_d;

    assign head     = mem_q[rd_q];
    assign count    = count_q;
    assign not_full = count_q < CNT_W'(DEPTH);

endmodule

// File: rtl/cdb_broadcaster.sv
// CDB transmit side: buffers FU results in per-FU FIFOs and broadcasts up to
// four per cycle on the registered 4-lane CDB, round-robin across FUs.
//   clk, rst : clock, synchronous active-high reset
//   flush    : mispredict flush, drops every buffered and same-cycle result
//   bus      : FU result inputs, per-FU ready, CDB outputs (lane 0 at MSB)
module cdb_broadcaster #(
    parameter int N_FU       = 6,
    parameter int FIFO_DEPTH = 2,
    parameter int ROB_W      = 4,
    parameter int DATA_W     = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    cdb_broadcaster_if.slave   bus
);
    import cdb_pkg::*;

    localparam int FU_W  = $clog2(N_FU);
    localparam int SW    = FU_W + 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    cdb_entry_t            fu_entry   [N_FU];
    cdb_entry_t            head       [N_FU];
    logic [CNT_W-1:0]      fifo_count [N_FU];
    logic [N_FU-1:0]       not_full, nonempty, fu_ready, push, grant;

    logic [FU_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [CDB_LANES-1:0]  cdb_vld_q, cdb_vld_d;
    cdb_lanes_t            cdb_lane_q, cdb_lane_d;

    logic [CDB_LANES-1:0]  lane_vld;
    cdb_lanes_t            lane_entry;
    logic [2:0]            used;
    logic [SW-1:0]         scan, nxt;
    logic [FU_W-1:0]       idx, last;

    assign fu_ready          = not_full & {N_FU{~rst}};
    assign bus.fu_ready_flat = fu_ready;
    assign push              = bus.fu_valid_flat & fu_ready & {N_FU{~flush}};

    for (genvar gi = 0; gi < N_FU; gi++) begin : g_fu
        assign fu_entry[gi] = '{rob_index: bus.fu_rob_index_flat[ROB_W*gi +: ROB_W],
                                result:    bus.fu_result_flat[DATA_W*gi +: DATA_W]};
        assign nonempty[gi] = fifo_count[gi] != '0;

        cdb_result_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
            .clk      (clk),
            .rst      (rst),
            .flush    (flush),
            .push     (push[gi]),
            .pop      (grant[gi]),
            .din      (fu_entry[gi]),
            .head     (head[gi]),
            .count    (fifo_count[gi]),
            .not_full (not_full[gi])
        );
    end

    // Round-robin scan starting at rr_ptr; first four non-empty FIFOs take
    // lanes 0..3 in scan order. Only registered heads are seen, so a push
    // never reaches the CDB in the cycle it arrives.
    always_comb begin
        grant      = '0;
        lane_vld   = '0;
        lane_entry = '0;
        used       = '0;
        last       = '0;
        scan       = '0;
        idx        = '0;
        nxt        = '0;
        rr_ptr_d   = rr_ptr_q;
        for (int j = 0; j < N_FU; j++) begin
            scan = {1'b0, rr_ptr_q} + SW'(j);
            if (scan >= SW'(N_FU)) scan = scan - SW'(N_FU);
            idx = scan[FU_W-1:0];
            if (nonempty[idx] && used < 3'd4) begin
                grant[idx]            = 1'b1;
                lane_vld[used[1:0]]   = 1'b1;
                lane_entry[used[1:0]] = head[idx];
                used                  = used + 3'd1;
                last                  = idx;
            end
        end
        // Pointer resumes just past the last winner; frozen across a flush.
        if (used != '0 && !flush) begin
            nxt = {1'b0, last} + SW'(1);
            if (nxt == SW'(N_FU)) nxt = '0;
            rr_ptr_d = nxt[FU_W-1:0];
        end
        cdb_vld_d  = flush ? '0 : lane_vld;
        cdb_lane_d = flush ? '0 : lane_entry;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q   <= '0;
            cdb_vld_q  <= '0;
            cdb_lane_q <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            cdb_vld_q  <= cdb_vld_d;
            cdb_lane_q <= cdb_lane_d;
        end
    end

    assign bus.cdb_valid_flat     = cdb_pack_valid(cdb_vld_q);
    assign bus.cdb_rob_index_flat = cdb_pack_rob(cdb_lane_q);
    assign bus.cdb_result_flat    = cdb_pack_result(cdb_lane_q);

    // An FU offering a result while not ready loses it.
    a_no_push_when_full: assert property (@(posedge clk) disable iff (rst)
        (bus.fu_valid_flat & ~fu_ready) == '0);

endmodule

// File: tb/tb_cdb_broadcaster.sv
module tb_cdb_broadcaster;
    import cdb_pkg::*;

    localparam int N_FU = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;
    always #5 clk = ~clk;

    cdb_broadcaster_if #(.N_FU(N_FU)) bus ();

    cdb_broadcaster #(.N_FU(N_FU), .FIFO_DEPTH(2), .ROB_W(4), .DATA_W(16)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus.slave)
    );

    int total = 0;
    int bad   = 0;

    typedef struct { logic [3:0] vld; logic [15:0] rob; logic [63:0] res; } cyc_t;
    typedef struct { int fu; logic [3:0] rob; logic [15:0] res; } ent_t;
    cyc_t exp_q[$];
    ent_t sb_q[$];

    int   mode = 0;     // 0: exact per-cycle expectations, 1: per-FU order scoreboard
    bit   steady = 1'b0;
    int   win = 0;
    int   gcnt [N_FU];
    int   seq  [N_FU];
    logic [3:0]  rob_v [N_FU];
    logic [15:0] res_v [N_FU];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic drive(input logic [N_FU-1:0] v);
        bus.fu_valid_flat = v;
        for (int i = 0; i < N_FU; i++) begin
            bus.fu_rob_index_flat[4*i +: 4] = rob_v[i];
            bus.fu_result_flat[16*i +: 16]  = res_v[i];
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_fu(input int i, input logic [3:0] r, input logic [15:0] d);
        rob_v[i] = r;
        res_v[i] = d;
    endtask

    task automatic expect_cyc(input logic [3:0] v, input logic [15:0] r, input logic [63:0] d);
        cyc_t c;
        c.vld = v; c.rob = r; c.res = d;
        exp_q.push_back(c);
    endtask

    // Push whatever each FU may push every cycle; record in the scoreboard.
    task automatic saturate(input int ncyc, input bit do_win);
        logic [N_FU-1:0] v;
        ent_t e;
        for (int c = 0; c < ncyc; c++) begin
            v = bus.fu_ready_flat;
            if (c >= 3) check("sat_ready_cnt", 64'($countones(v)), 64'd4);
            for (int i = 0; i < N_FU; i++) if (v[i]) begin
                rob_v[i] = seq[i][3:0];
                res_v[i] = {i[3:0], seq[i][11:0]};
                e.fu = i; e.rob = rob_v[i]; e.res = res_v[i];
                sb_q.push_back(e);
                seq[i]++;
            end
            drive(v);
            if (c == 3) steady = 1'b1;
            if (do_win && c == 6) win = 30;
            step(1);
        end
        steady = 1'b0;
    endtask

    // Monitor: samples 2 time units after each rising edge.
    initial begin : monitor
        cyc_t       e;
        cdb_lanes_t lanes;
        int         f, found;
        forever begin
            @(posedge clk);
            #2;
            lanes = cdb_unpack(bus.cdb_rob_index_flat, bus.cdb_result_flat);
            if (mode == 0) begin
                if (bus.cdb_valid_flat != '0) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_cdb", 64'(bus.cdb_valid_flat), 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("cdb_valid", 64'(bus.cdb_valid_flat), 64'(e.vld));
                        check("cdb_rob", 64'(bus.cdb_rob_index_flat), 64'(e.rob));
                        check("cdb_result", bus.cdb_result_flat, e.res);
                    end
                end
            end else begin
                if (steady) check("sat_all_lanes", 64'(bus.cdb_valid_flat), 64'hF);
                for (int k = 0; k < 4; k++) if (bus.cdb_valid_flat[3-k]) begin
                    f = int'(lanes[k].result[15:12]);
                    found = -1;
                    for (int j = 0; j < sb_q.size(); j++) begin
                        if (sb_q[j].fu == f) begin
                            found = j;
                            break;
                        end
                    end
                    if (found < 0) begin
                        check("sat_unexpected", 64'd1, 64'd0);
                    end else begin
                        check("sat_rob", 64'(lanes[k].rob_index), 64'(sb_q[found].rob));
                        check("sat_res", 64'(lanes[k].result), 64'(sb_q[found].res));
                        sb_q.delete(found);
                    end
                    if (win > 0 && f < N_FU) gcnt[f]++;
                end
                if (win > 0) win--;
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        for (int i = 0; i < N_FU; i++) begin
            rob_v[i] = '0; res_v[i] = '0; seq[i] = 0; gcnt[i] = 0;
        end
        drive('0);
        rst = 1'b1;

        // Reset state
        step(2);
        check("rst_ready", 64'(bus.fu_ready_flat), 64'd0);
        check("rst_valid", 64'(bus.cdb_valid_flat), 64'd0);
        check("rst_rob", 64'(bus.cdb_rob_index_flat), 64'd0);
        check("rst_result", bus.cdb_result_flat, 64'd0);
        rst = 1'b0;
        #1;
        check("ready_after_rst", 64'(bus.fu_ready_flat), 64'h3F);

        // Single result from FU2
        set_fu(2, 4'd5, 16'h1234);
        expect_cyc(4'b1000, 16'h5000, 64'h1234_0000_0000_0000);
        drive(6'b000100); step(1); drive('0); step(2);
        check("single_then_idle", 64'(bus.cdb_valid_flat), 64'd0);
        check("single_drained", 64'(exp_q.size()), 64'd0);

        // FU5 alone moves rr_ptr to 0
        set_fu(5, 4'd1, 16'hAAAA);
        expect_cyc(4'b1000, 16'h1000, 64'hAAAA_0000_0000_0000);
        drive(6'b100000); step(1); drive('0); step(2);

        // Burst of six from rr_ptr=0
        for (int i = 0; i < N_FU; i++) set_fu(i, 4'(i), 16'h0100 + 16'(i));
        expect_cyc(4'b1111, 16'h0123, 64'h0100_0101_0102_0103);
        expect_cyc(4'b1100, 16'h4500, 64'h0104_0105_0000_0000);
        drive(6'b111111); step(1); drive('0); step(3);
        check("burst_idle", 64'(bus.cdb_valid_flat), 64'd0);
        check("burst_drained", 64'(exp_q.size()), 64'd0);

        // Wrap-around: FU4 alone sets rr_ptr=5, then FUs 5,0,1
        set_fu(4, 4'd7, 16'h4444);
        expect_cyc(4'b1000, 16'h7000, 64'h4444_0000_0000_0000);
        drive(6'b010000); step(1); drive('0); step(2);
        set_fu(5, 4'd13, 16'hB005);
        set_fu(0, 4'd8, 16'hB000);
        set_fu(1, 4'd9, 16'hB001);
        expect_cyc(4'b1110, 16'hD890, 64'hB005_B000_B001_0000);
        drive(6'b100011); step(1); drive('0); step(2);
        // rr_ptr should now be 2: FU2 ahead of FU1
        set_fu(2, 4'd3, 16'hC002);
        set_fu(1, 4'd4, 16'hC001);
        expect_cyc(4'b1100, 16'h3400, 64'hC002_C001_0000_0000);
        drive(6'b000110); step(1); drive('0); step(2);
        check("wrap_drained", 64'(exp_q.size()), 64'd0);

        // Flush with buffered entries and a same-cycle push
        for (int i = 0; i < N_FU; i++) set_fu(i, 4'(i), 16'hD000 + 16'(i));
        expect_cyc(4'b1111, 16'h2345, 64'hD002_D003_D004_D005);
        drive(6'b111111); step(1);
        for (int i = 1; i < N_FU; i++) set_fu(i, 4'(i + 6), 16'hE000 + 16'(i));
        drive(6'b111110); step(1);
        flush = 1'b1;
        set_fu(0, 4'd15, 16'hFFFF);
        check("flush_fu0_ready", 64'(bus.fu_ready_flat[0]), 64'd1);
        drive(6'b000001); step(1);
        flush = 1'b0;
        drive('0);
        check("flush_valid", 64'(bus.cdb_valid_flat), 64'd0);
        check("flush_ready", 64'(bus.fu_ready_flat), 64'h3F);
        step(4);
        check("flush_drained", 64'(exp_q.size()), 64'd0);
        // rr_ptr held at 0 and FIFOs empty: FU0 then FU5
        set_fu(0, 4'd1, 16'h0F00);
        set_fu(5, 4'd2, 16'h0F05);
        expect_cyc(4'b1100, 16'h1200, 64'h0F00_0F05_0000_0000);
        drive(6'b100001); step(1); drive('0); step(2);
        check("post_flush_drained", 64'(exp_q.size()), 64'd0);

        // Saturation with per-FU ordering and fairness
        mode = 1;
        saturate(60, 1'b1);
        drive('0);
        step(5);
        check("sat_all_broadcast", 64'(sb_q.size()), 64'd0);
        for (int i = 0; i < N_FU; i++) check($sformatf("sat_grants_fu%0d", i), 64'(gcnt[i]), 64'd20);

        // Reset during saturation
        saturate(10, 1'b0);
        rst = 1'b1;
        #1;
        drive('0);
        check("midrst_ready0", 64'(bus.fu_ready_flat), 64'd0);
        step(1);
        check("midrst_valid", 64'(bus.cdb_valid_flat), 64'd0);
        check("midrst_rob", 64'(bus.cdb_rob_index_flat), 64'd0);
        check("midrst_result", bus.cdb_result_flat, 64'd0);
        sb_q.delete();
        mode = 0;
        step(1);
        check("midrst_ready1", 64'(bus.fu_ready_flat), 64'd0);
        rst = 1'b0;
        step(3);
        set_fu(3, 4'd9, 16'h3939);
        expect_cyc(4'b1000, 16'h9000, 64'h3939_0000_0000_0000);
        drive(6'b001000); step(1); drive('0); step(3);
        check("post_rst_drained", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
